// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined log-shifter (LSL/LSR/ASL/ASR/ROL/ROR) with a
// valid/ready handshake, carry-out flag and ASL signed-overflow flag.
// Ports: clk, rst (async, active-high);
//        in_valid/in_ready/in_data/in_amt/in_op  - operation request;
//        out_valid/out_ready/out_data/out_carry/out_ovf - result.
module barrel_shifter_pipe #(
   parameter int WIDTH  = 64,
   parameter int SHW    = $clog2(WIDTH),
   parameter int STAGES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_ovf
);

   localparam logic [2:0] OP_LSL = 3'b000;
   localparam logic [2:0] OP_LSR = 3'b001;
   localparam logic [2:0] OP_ASL = 3'b010;
   localparam logic [2:0] OP_ASR = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b101;

   typedef struct packed {
      logic             valid;
      logic [2:0]       op;
      logic [SHW-1:0]   amt;
      logic [WIDTH-1:0] data;
      logic             cy;
      logic             ov;
   } stg_t;

   stg_t head;
   stg_t tail;
   stg_t pipe_d [STAGES];
   stg_t pipe_q [STAGES];
   logic adv;
   logic amt_nz;

   assign tail     = pipe_q[STAGES-1];
   assign adv      = !tail.valid || out_ready;
   assign in_ready = adv;

   always_comb begin
      head       = '0;
      head.valid = in_valid;
      head.op    = in_op;
      head.amt   = in_amt;
      head.data  = in_data;
   end

   // Level k shifts by 2^k and lives in stage floor(k*STAGES/SHW).
   // A level takes its input from the previous level when both share a
   // stage, otherwise from the register closing the previous stage.
   for (genvar k = 0; k < SHW; k++) begin : lvl
      localparam int SH = 1 << k;
      localparam int S  = (k * STAGES) / SHW;
      localparam int SP = (k == 0) ? 0 : ((k - 1) * STAGES) / SHW;
      localparam int SN = ((k + 1) * STAGES) / SHW;

      stg_t        i;
      stg_t        o;
      logic [SH:0] top;

      if (k == 0) begin : g_head
         assign i = head;
      end else if (S != SP) begin : g_reg
         assign i = pipe_q[S-1];
      end else begin : g_chain
         assign i = lvl[k-1].o;
      end

      // Bits that must match the sign for this partial ASL to be lossless.
      assign top = i.data[WIDTH-1 -: SH+1];

      // The carry is overwritten by every applied level: the last level
      // applied removes the bit that was shifted out last overall.
      // Overflow accumulates since adjacent windows overlap by one bit.
      always_comb begin
         o = i;
         if (i.amt[k]) begin
            case (i.op)
               OP_LSL, OP_ASL: begin
                  o.data = i.data << SH;
                  o.cy   = i.data[WIDTH-SH];
                  if (i.op == OP_ASL && top != '0 && top != '1)
                     o.ov = 1'b1;
               end
               OP_LSR: begin
                  o.data = i.data >> SH;
                  o.cy   = i.data[SH-1];
               end
               OP_ASR: begin
                  o.data = WIDTH'($signed(i.data) >>> SH);
                  o.cy   = i.data[SH-1];
               end
               OP_ROL: begin
                  o.data = (i.data << SH) | (i.data >> (WIDTH - SH));
               end
               OP_ROR: begin
                  o.data = (i.data >> SH) | (i.data << (WIDTH - SH));
               end
               default: begin
                  o = i;
               end
            endcase
         end
      end

      if (k == SHW - 1 || SN != S) begin : g_tap
         assign pipe_d[S] = o;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++)
            pipe_q[s] <= '0;
      end else if (adv) begin
         for (int s = 0; s < STAGES; s++)
            pipe_q[s] <= pipe_d[s];
      end
   end

   // Rotate carry is a bit of the final result, so it is picked at the end.
   assign amt_nz = |tail.amt;

   always_comb begin
      out_carry = tail.cy;
      if (amt_nz) begin
         if (tail.op == OP_ROL)
            out_carry = tail.data[0];
         else if (tail.op == OP_ROR)
            out_carry = tail.data[WIDTH-1];
      end
   end

   assign out_valid = tail.valid;
   assign out_data  = tail.data;
   assign out_ovf   = tail.ov;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed bench for barrel_shifter_pipe (64b/3 stages)
// plus an 8b/1-stage instance checked against a bitwise reference function.
module tb_barrel_shifter_pipe;

   localparam int ST = 3;

   localparam logic [2:0] LSL = 3'd0;
   localparam logic [2:0] LSR = 3'd1;
   localparam logic [2:0] ASL = 3'd2;
   localparam logic [2:0] ASR = 3'd3;
   localparam logic [2:0] ROL = 3'd4;
   localparam logic [2:0] ROR = 3'd5;
   localparam logic [2:0] RSV = 3'd6;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [5:0]  in_amt;
   logic [2:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_carry;
   logic        out_ovf;

   logic        s_in_valid;
   logic        s_in_ready;
   logic [7:0]  s_in_data;
   logic [2:0]  s_in_amt;
   logic [2:0]  s_in_op;
   logic        s_out_valid;
   logic        s_out_ready;
   logic [7:0]  s_out_data;
   logic        s_out_carry;
   logic        s_out_ovf;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   barrel_shifter_pipe #(.WIDTH(64), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_carry (out_carry),
      .out_ovf   (out_ovf)
   );

   barrel_shifter_pipe #(.WIDTH(8), .STAGES(1)) u_small (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .in_amt    (s_in_amt),
      .in_op     (s_in_op),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_data  (s_out_data),
      .out_carry (s_out_carry),
      .out_ovf   (s_out_ovf)
   );

   task automatic chk_d(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One op through an empty pipe; result must appear exactly ST cycles on.
   task automatic run1(input string tag, input logic [2:0] op,
                       input logic [63:0] d, input logic [5:0] a,
                       input logic [63:0] ed, input logic ec,
                       input logic eo);
      in_valid  = 1'b1;
      in_op     = op;
      in_data   = d;
      in_amt    = a;
      out_ready = 1'b1;
      #1;
      chk_b({tag, "_rdy"}, in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      for (int c = 1; c < ST; c++) begin
         chk_b({tag, "_early"}, out_valid, 1'b0);
         tick();
      end
      chk_b({tag, "_vld"}, out_valid, 1'b1);
      chk_d({tag, "_data"}, out_data, ed);
      chk_b({tag, "_cy"}, out_carry, ec);
      chk_b({tag, "_ov"}, out_ovf, eo);
      tick();
   endtask

   // Bitwise reference for the 8-bit instance: {ovf, carry, data}.
   function automatic logic [9:0] ref8(input logic [2:0] op,
                                       input logic [7:0] d,
                                       input logic [2:0] a);
      logic [7:0] r;
      logic       c;
      logic       v;
      int         n;
      n = int'(a);
      r = d;
      c = 1'b0;
      v = 1'b0;
      case (op)
         3'd0, 3'd2: begin
            r = d << n;
            if (n != 0) c = d[8-n];
            if (op == 3'd2)
               for (int j = 7 - n; j < 7; j++)
                  if (d[j] != d[7]) v = 1'b1;
         end
         3'd1: begin
            r = d >> n;
            if (n != 0) c = d[n-1];
         end
         3'd3: begin
            for (int j = 0; j < 8; j++)
               r[j] = (j + n > 7) ? d[7] : d[j+n];
            if (n != 0) c = d[n-1];
         end
         3'd4: begin
            r = (d << n) | (d >> (8 - n));
            if (n != 0) c = r[0];
         end
         3'd5: begin
            r = (d >> n) | (d << (8 - n));
            if (n != 0) c = r[7];
         end
         default: r = d;
      endcase
      return {v, c, r};
   endfunction

   initial begin
      int          nin;
      int          nout;
      int          first;
      int          last;
      logic [9:0]  exp8;

      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      in_amt      = '0;
      in_op       = LSL;
      out_ready   = 1'b0;
      s_in_valid  = 1'b0;
      s_in_data   = '0;
      s_in_amt    = '0;
      s_in_op     = LSL;
      s_out_ready = 1'b1;

      // Reset state
      #12;
      chk_b("rst_vld", out_valid, 1'b0);
      chk_d("rst_data", out_data, 64'h0);
      chk_b("rst_cy", out_carry, 1'b0);
      chk_b("rst_ov", out_ovf, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      chk_b("rst_rdy", in_ready, 1'b1);
      chk_b("s_rst_vld", s_out_valid, 1'b0);
      tick();

      // Shifts and rotates
      run1("lsl63", LSL, 64'h1, 6'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
      run1("lsr4", LSR, 64'h8000_0000_0000_00F1, 6'd4,
           64'h0800_0000_0000_000F, 1'b0, 1'b0);
      run1("lsr1", LSR, 64'hF1, 6'd1, 64'h78, 1'b1, 1'b0);
      run1("asr4", ASR, 64'h8000_0000_0000_0000, 6'd4,
           64'hF800_0000_0000_0000, 1'b0, 1'b0);
      run1("asr4c", ASR, 64'h8000_0000_0000_0008, 6'd4,
           64'hF800_0000_0000_0000, 1'b1, 1'b0);
      run1("ror1", ROR, 64'h1, 6'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
      run1("rol4", ROL, 64'h8000_0000_0000_0001, 6'd4, 64'h18, 1'b0, 1'b0);
      run1("lsl0", LSL, 64'hDEAD_BEEF_0123_4567, 6'd0,
           64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
      run1("ror0", ROR, 64'h8000_0000_0000_0001, 6'd0,
           64'h8000_0000_0000_0001, 1'b0, 1'b0);
      run1("asl0", ASL, 64'h4000_0000_0000_0000, 6'd0,
           64'h4000_0000_0000_0000, 1'b0, 1'b0);

      // Overflow
      run1("asl_ov", ASL, 64'h4000_0000_0000_0000, 6'd1,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
      run1("asl_cy", ASL, 64'hC000_0000_0000_0000, 6'd1,
           64'h8000_0000_0000_0000, 1'b1, 1'b0);
      run1("asl3_ov", ASL, 64'h1000_0000_0000_0000, 6'd3,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
      run1("asl3_ok", ASL, 64'h0800_0000_0000_0000, 6'd3,
           64'h4000_0000_0000_0000, 1'b0, 1'b0);
      run1("lsl_noov", LSL, 64'h4000_0000_0000_0000, 6'd1,
           64'h8000_0000_0000_0000, 1'b0, 1'b0);

      // Reserved op
      run1("rsv", RSV, 64'h1234_5678_9ABC_DEF0, 6'd5,
           64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
      run1("rsv7", 3'd7, 64'hFFFF_0000_FFFF_0000, 6'd33,
           64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0);

      // Backpressure: out_ready low for 6 cycles, 6 ops offered
      nin   = 0;
      nout  = 0;
      first = -1;
      last  = -1;
      for (int c = 0; c < 40 && nout < 6; c++) begin
         out_ready = (c >= 6);
         in_valid  = (nin < 6);
         in_op     = LSL;
         in_data   = 64'(nin + 1);
         in_amt    = 6'(nin);
         #1;
         if (c < 6) chk_b("bp_ready", in_ready, (c < 3));
         if (c == 3 || c == 5) begin
            chk_b("bp_hold_vld", out_valid, 1'b1);
            chk_d("bp_hold_data", out_data, 64'h1);
         end
         if (out_valid && out_ready) begin
            chk_d("bp_order", out_data, 64'(nout + 1) << nout);
            if (first < 0) first = c;
            last = c;
            nout++;
         end
         if (in_valid && in_ready) nin++;
         tick();
      end
      in_valid = 1'b0;
      chk_d("bp_count", 64'(nout), 64'd6);
      chk_d("bp_accepted", 64'(nin), 64'd6);
      chk_d("bp_span", 64'(last - first), 64'd5);
      chk_d("bp_first", 64'(first), 64'd6);
      tick();
      chk_b("bp_drained", out_valid, 1'b0);

      // Reset with two ops in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op     = LSL;
      in_amt    = 6'd1;
      in_data   = 64'h1;
      tick();
      in_data = 64'h2;
      tick();
      in_valid = 1'b0;
      tick();
      chk_b("mr_pre", out_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk_b("mr_drop", out_valid, 1'b0);
      tick();
      tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         chk_b("mr_quiet", out_valid, 1'b0);
         tick();
      end
      run1("mr_new", LSR, 64'hF0, 6'd4, 64'hF, 1'b0, 1'b0);

      // 8-bit, single-stage instance: every op at amt 0, then random
      s_in_valid = 1'b1;
      for (int t = 0; t < 48; t++) begin
         s_in_op   = (t < 16) ? 3'(t % 8) : 3'($urandom_range(0, 7));
         s_in_amt  = (t < 8) ? 3'd0 : 3'($urandom);
         s_in_data = 8'($urandom);
         exp8      = ref8(s_in_op, s_in_data, s_in_amt);
         #1;
         chk_b("s_rdy", s_in_ready, 1'b1);
         tick();
         chk_b("s_vld", s_out_valid, 1'b1);
         chk_d("s_data", {56'd0, s_out_data}, {56'd0, exp8[7:0]});
         chk_b("s_cy", s_out_carry, exp8[8]);
         chk_b("s_ov", s_out_ovf, exp8[9]);
      end
      s_in_valid = 1'b0;
      tick();
      chk_b("s_idle", s_out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter with a valid/ready handshake. It is the next-generation shifter for the ALU cores. It generalises the fixed 64-bit, four-mode combinational shifter in three ways: configurable data width, configurable pipeline depth, and six operations including rotates. It also reports carry-out and signed-overflow flags. It sits between the ALU operand/issue logic and the result writeback mux, and applies backpressure through `in_ready`.

## Interface
- `WIDTH`, default 64: data width; must be a power of two, ≥ 8.
- `SHW`, default $clog2(WIDTH): shift-amount width (derived; not overridden).
- `STAGES`, default 3: pipeline register stages; legal range 1..SHW.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous assert, active-high; released synchronously to `clk` by the system.
- `in_valid`  in  1  input operation valid.
- `in_ready`  out  1  shifter can accept an operation this cycle.
- `in_data`  in  WIDTH  operand.
- `in_amt`  in  SHW  shift/rotate amount, unsigned, 0..WIDTH-1.
- `in_op`  in  3  operation: 000 LSL, 001 LSR, 010 ASL, 011 ASR, 100 ROL, 101 ROR, 110/111 reserved.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result this cycle.
- `out_data`  out  WIDTH  shifted result.
- `out_carry`  out  1  carry-out flag.
- `out_ovf`  out  1  signed-overflow flag (ASL only).

## Operation
- **Handshake:** an input transfer occurs when `in_valid && in_ready`; an output transfer occurs when `out_valid && out_ready`.
- **Global advance:** `adv = !out_valid || out_ready`, and `in_ready = adv`, combinational.
  - When `adv` is 1, every stage shifts forward one position.
  - When `adv` is 0, all stages hold their contents.
  - Bubbles advance as `valid=0`.
- **Shift decomposition:** the shift is built from SHW mux levels; level k shifts by 2^k when `in_amt[k]` is 1.
  - Level k is placed in stage floor(k*STAGES/SHW).
  - Each stage register carries the partial data plus `op`, `amt`, `valid` and partial flags.
- **Results:**
  - LSL: `in_data << amt`, zero fill.
  - LSR: `in_data >> amt`, zero fill.
  - ASL: same data as LSL.
  - ASR: right shift, filled with `in_data[WIDTH-1]`.
  - ROL / ROR: rotate left / right by `amt`.
  - Reserved ops: `out_data = in_data`, both flags 0.
- **out_carry:**
  - If `amt == 0`, it is 0 for all ops.
  - LSL/ASL: `in_data[WIDTH-amt]`, the last bit shifted out.
  - LSR/ASR: `in_data[amt-1]`.
  - ROL: `out_data[0]`.
  - ROR: `out_data[WIDTH-1]`.
- **out_ovf:**
  - ASL only: 1 iff bits `in_data[WIDTH-1 : WIDTH-1-amt]` are not all equal, meaning the sign changed or significant bits were lost.
  - 0 for `amt == 0` and for every other op.
- **Width rules:** the amount is taken modulo WIDTH by construction (SHW bits), so no out-of-range case exists.

## Timing
- **Latency:** exactly STAGES cycles from input transfer to `out_valid`, with no stall.
- **Throughput:** one op per cycle while `out_ready` stays high.
- **Ordering:** results leave in acceptance order; at most STAGES ops are in flight.
- **Stall:** with `out_valid=1` and `out_ready=0`, `in_ready=0` and the pipe freezes, including any internal bubbles. No bubble collapsing takes place.
  - `out_data`, `out_carry` and `out_ovf` stay stable while stalled.
- **Simultaneous events:** output transfer and input transfer in the same cycle are allowed (`adv=1`).
- **Reset values:** `out_valid=0`, `out_data=0`, `out_carry=0`, `out_ovf=0`, and all stage valids 0.
  - After reset, `in_ready=1` in the first cycle (follows from `out_valid=0`).
- **Reset mid-operation:** all in-flight ops are discarded and none appear after deassert. The first op accepted after reset emerges STAGES cycles later.
- **Handshake rule:** `out_valid` does not depend combinationally on `out_ready`.

## Test plan
All scenarios use WIDTH=64 and STAGES=3 unless stated.
- **Shifts:**
  - LSL `in_data=0x1`, amt=63 → `0x8000_0000_0000_0000`, carry=0, ovf=0, 3 cycles after accept.
  - LSR `0x8000_0000_0000_00F1`, amt=4 → `0x0800_0000_0000_000F`, carry=0.
  - ASR `0x8000_0000_0000_0000`, amt=4 → `0xF800_0000_0000_0000`, carry=0.
- **Rotates:**
  - ROR `0x1`, amt=1 → `0x8000_0000_0000_0000`, carry=1.
  - ROL `0x8000_0000_0000_0001`, amt=4 → `0x18`, carry=0.
  - Any op with amt=0 → data unchanged, flags 0.
- **Overflow:**
  - ASL `0x4000_0000_0000_0000`, amt=1 → `0x8000_0000_0000_0000`, ovf=1.
  - ASL `0xC000_0000_0000_0000`, amt=1 → ovf=0, carry=1.
- **Backpressure:** 6 back-to-back ops with `out_ready=0` for the first 6 cycles.
  - 3 ops are accepted, then `in_ready=0`.
  - Outputs hold stable.
  - On releasing `out_ready`, all 6 results emerge in order, one per cycle, with none lost or duplicated.
- **Reset mid-operation:** assert `rst` asynchronously with 2 ops in flight.
  - `out_valid` drops immediately and stays 0.
  - A new op accepted after release appears exactly 3 cycles later.
- **Parameter sweep:** WIDTH ∈ {8, 32, 64} × STAGES ∈ {1, SHW}, with random ops/amounts against a reference model.
  - Latency equals STAGES.
  - Reserved ops pass data through with flags 0.
